timer: RTL and testbench

Memory-mapped programmable countdown timer that answers the processor-side bridge's timer window. The bridge passes the word-address bits, write data and a write strobe. The timer drives read data back to the bridge and raises an interrupt request toward the CPU's exception logic. It holds three word registers, CTRL, PRESET and COUNT, and supports one-shot and auto-reload modes.

---
 rtl/timer_pkg.sv | 39 +++
 rtl/timer_prescaler.sv | 37 +++
 rtl/timer.sv | 164 ++++++++++++++++
 tb/tb_timer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared constants for the memory-mapped countdown timer:
//                register indices, CTRL bit positions, mode encodings and
//                FSM state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    // Word-register indices, decoded from bridge address bits [3:2]
    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;

    // CTRL field positions
    localparam int unsigned c_ctrl_en_bit   = 0;
    localparam int unsigned c_ctrl_mode_lsb = 1;
    localparam int unsigned c_ctrl_mode_msb = 2;
    localparam int unsigned c_ctrl_im_bit   = 3;

    // Mode encodings; 2'b1x falls back to one-shot behaviour
    localparam logic [1:0] c_mode_oneshot = 2'b00;
    localparam logic [1:0] c_mode_reload  = 2'b01;

    // FSM state encodings
    typedef logic [1:0] timer_state_t;
    localparam timer_state_t c_st_idle = 2'd0;
    localparam timer_state_t c_st_load = 2'd1;
    localparam timer_state_t c_st_cnt  = 2'd2;
    localparam timer_state_t c_st_int  = 2'd3;

    // Only the exact auto-reload encoding reloads; everything else is one-shot
    function automatic logic is_reload_mode(input logic [1:0] mode);
        return (mode == c_mode_reload);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : 16-bit clock divider producing a one-cycle tick every
//                PRESCALE clocks. clr holds the divider at 0 so that each
//                counting run starts with a full prescale period.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_prescaler #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] c_last = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;

    // Tick on the last clock of each prescale period
    assign tick = (r_cnt == c_last);

    // Free-running divider, restarted by clr and on every tick
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= 16'd0;
        end else if (tick) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer.sv
`default_nettype none
// ============================================================================
//  Module      : timer
//  Description : Memory-mapped programmable countdown timer with CTRL,
//                PRESET and COUNT word registers, one-shot and auto-reload
//                modes and a registered, maskable interrupt request.
//                Optional feature macro: TIMER_PRESCALE_EN (divides the
//                COUNT decrement rate by PRESCALE).
//  Revision    : 1.0  initial release
// ============================================================================
module timer
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  dev_addr,
    input  logic [31:0] dev_wd,
    input  logic        we_timer,
    output logic [31:0] dev_rd,
    output logic        irq
);

    // Reject an illegal divider at elaboration time
    generate
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_prescale_range
            $error("timer: PRESCALE must lie in 1..65535");
        end
    endgenerate

    logic [3:0]   r_ctrl;
    logic [31:0]  r_preset;
    logic [31:0]  r_count;
    logic         r_irq_pending;
    logic         r_irq;
    timer_state_t r_state;

    logic w_ctrl_we;
    logic w_preset_we;
    logic w_enable;
    logic w_reload;
    logic w_tick;
    logic w_irq_set;
    logic w_oneshot_done;
    logic w_reload_done;

    assign w_ctrl_we      = we_timer && (dev_addr == TIMER_CTRL);
    assign w_preset_we    = we_timer && (dev_addr == TIMER_PRESET);
    assign w_enable       = r_ctrl[c_ctrl_en_bit];
    assign w_reload       = is_reload_mode(r_ctrl[c_ctrl_mode_msb:c_ctrl_mode_lsb]);
    // The zero check is deliberately not gated by the prescale tick
    assign w_irq_set      = (r_state == c_st_cnt) && w_enable && (r_count == 32'd0);
    assign w_oneshot_done = (r_state == c_st_int) && !w_reload;
    assign w_reload_done  = (r_state == c_st_int) && w_reload;

`ifdef TIMER_PRESCALE_EN
    logic w_prescale_clr;

    // Divider only runs while counting, so every LOAD restarts it from 0
    assign w_prescale_clr = (r_state != c_st_cnt);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (w_prescale_clr),
        .tick  (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    // Control FSM and COUNT register; a disabled count is parked, never resumed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_count <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_enable) begin
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_count <= r_preset;
                    r_state <= c_st_cnt;
                end
                c_st_cnt: begin
                    if (!w_enable) begin
                        r_state <= c_st_idle;
                    end else if (r_count == 32'd0) begin
                        r_state <= c_st_int;
                    end else if (w_tick) begin
                        r_count <= r_count - 32'd1;
                    end
                end
                c_st_int: begin
                    r_state <= w_reload ? c_st_load : c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // CTRL register; a CPU write overrides the one-shot Enable clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= 4'd0;
        end else if (w_ctrl_we) begin
            r_ctrl <= dev_wd[3:0];
        end else if (w_oneshot_done) begin
            r_ctrl[c_ctrl_en_bit] <= 1'b0;
        end
    end

    // PRESET register; only sampled by the FSM in LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            r_preset <= 32'd0;
        end else if (w_preset_we) begin
            r_preset <= dev_wd;
        end
    end

    // Pending flag: a hardware set beats a simultaneous CTRL-write clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_pending <= 1'b0;
        end else if (w_irq_set) begin
            r_irq_pending <= 1'b1;
        end else if (w_ctrl_we || w_reload_done) begin
            r_irq_pending <= 1'b0;
        end
    end

    // Registered, masked interrupt request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl[c_ctrl_im_bit] & r_irq_pending;
        end
    end

    // Zero-latency read mux
    always_comb begin
        dev_rd = 32'd0;
        case (dev_addr)
            TIMER_CTRL:   dev_rd = {28'd0, r_ctrl};
            TIMER_PRESET: dev_rd = r_preset;
            TIMER_COUNT:  dev_rd = r_count;
            default:      dev_rd = 32'd0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer
//  Description : Self-checking bench for timer: vector table for the
//                one-shot walk, hand sequences for multi-cycle corner cases
//                and a randomized phase against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer;

`ifdef TIMER_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [3:2]  dev_addr = 2'd0;
    logic [31:0] dev_wd   = 32'd0;
    logic        we_timer = 1'b0;
    logic [31:0] dev_rd;
    logic        irq;

    timer #(
        .PRESCALE (P)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .we_timer (we_timer),
        .dev_rd   (dev_rd),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural reference model ----------------
    // Phases of one timer run: waiting, loading PRESET, counting, expired.
    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_COUNT = 2;
    localparam int PH_FIRE  = 3;

    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_pend;
    bit          m_irq;
    int          m_phase;
    int          m_pre;

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset;
        logic [31:0] n_count;
        bit          n_pend;
        bit          fire_now;
        bit          tick;
        bit          en;
        bit          auto_mode;
        int          n_phase;
        int          n_pre;
        if (reset) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
            m_pend = 1'b0; m_irq = 1'b0; m_phase = PH_IDLE; m_pre = 0;
            return;
        end
        en        = m_ctrl[0];
        auto_mode = (m_ctrl[2:1] == 2'b01);
        tick      = (P == 1) || (m_pre == P - 1);
        n_pre     = (m_phase == PH_COUNT && !tick) ? m_pre + 1 : 0;
        n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
        n_pend = m_pend; n_phase = m_phase; fire_now = 1'b0;
        case (m_phase)
            PH_IDLE: if (en) n_phase = PH_LOAD;
            PH_LOAD: begin n_count = m_preset; n_phase = PH_COUNT; end
            PH_COUNT: begin
                if (!en) n_phase = PH_IDLE;
                else if (m_count == 0) begin n_phase = PH_FIRE; fire_now = 1'b1; end
                else if (tick) n_count = m_count - 1;
            end
            default: begin
                if (auto_mode) begin n_phase = PH_LOAD; n_pend = 1'b0; end
                else begin n_ctrl[0] = 1'b0; n_phase = PH_IDLE; end
            end
        endcase
        if (we_timer && dev_addr == 2'd0) begin
            n_ctrl = dev_wd[3:0];
            n_pend = 1'b0;
        end
        if (fire_now) n_pend = 1'b1;
        if (we_timer && dev_addr == 2'd1) n_preset = dev_wd;
        m_irq    = m_ctrl[3] & m_pend;
        m_ctrl   = n_ctrl; m_preset = n_preset; m_count = n_count;
        m_pend   = n_pend; m_phase = n_phase; m_pre = n_pre;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Let one rising edge pass (model follows it), then apply new inputs
    task automatic drive(input logic r, input logic [1:0] a, input logic [31:0] wd, input logic we);
        @(posedge clk);
        model_step();
        @(negedge clk);
        reset = r; dev_addr = a; dev_wd = wd; we_timer = we;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 2'd0, 32'd0, 1'b0);
        drive(1'b0, 2'd0, 32'd0, 1'b0);
    endtask

    typedef struct {
        logic        r;
        logic [1:0]  a;
        logic [31:0] wd;
        logic        we;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [1:0] a, input logic [31:0] wd, input logic we,
                               input logic [31:0] exp_rd, input logic exp_irq);
        vec_t t;
        t.r = 1'b0; t.a = a; t.wd = wd; t.we = we; t.exp_rd = exp_rd; t.exp_irq = exp_irq;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int found;
        // Reset then all-zero reads
        vecs.push_back(v(2'd0, 32'd0, 1'b0, 32'd0, 1'b0));
        vecs.push_back(v(2'd1, 32'd0, 1'b0, 32'd0, 1'b0));
        vecs.push_back(v(2'd2, 32'd0, 1'b0, 32'd0, 1'b0));
        vecs.push_back(v(2'd3, 32'd0, 1'b0, 32'd0, 1'b0));
`ifndef TIMER_PRESCALE_EN
        // One-shot, IM=1, PRESET=3
        vecs.push_back(v(2'd1, 32'd3, 1'b1, 32'd0, 1'b0));
        vecs.push_back(v(2'd0, 32'h9, 1'b1, 32'd0, 1'b0));
        vecs.push_back(v(2'd0, 32'd0, 1'b0, 32'h9, 1'b0));
        vecs.push_back(v(2'd2, 32'd0, 1'b0, 32'd0, 1'b0));
        vecs.push_back(v(2'd2, 32'd0, 1'b0, 32'd3, 1'b0));
        vecs.push_back(v(2'd2, 32'd0, 1'b0, 32'd2, 1'b0));
        vecs.push_back(v(2'd2, 32'd0, 1'b0, 32'd1, 1'b0));
        vecs.push_back(v(2'd2, 32'd0, 1'b0, 32'd0, 1'b0));
        vecs.push_back(v(2'd2, 32'd0, 1'b0, 32'd0, 1'b0));
        vecs.push_back(v(2'd0, 32'd0, 1'b0, 32'h8, 1'b1));
        vecs.push_back(v(2'd0, 32'd0, 1'b0, 32'h8, 1'b1));
        vecs.push_back(v(2'd0, 32'd0, 1'b1, 32'h8, 1'b1));
        vecs.push_back(v(2'd0, 32'd0, 1'b0, 32'h0, 1'b1));
        vecs.push_back(v(2'd0, 32'd0, 1'b0, 32'h0, 1'b0));
        vecs.push_back(v(2'd0, 32'd0, 1'b0, 32'h0, 1'b0));
`endif

        drive(1'b1, 2'd0, 32'd0, 1'b0);
        drive(1'b1, 2'd0, 32'd0, 1'b0);
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].a, vecs[i].wd, vecs[i].we);
            check($sformatf("tbl[%0d].rd", i), dev_rd, vecs[i].exp_rd);
            check($sformatf("tbl[%0d].irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

`ifndef TIMER_PRESCALE_EN
        // Auto-reload, PRESET=2: one-cycle irq pulse every 5 clocks
        do_reset();
        drive(1'b0, 2'd1, 32'd2, 1'b1);
        drive(1'b0, 2'd0, 32'hB, 1'b1);
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            drive(1'b0, 2'd2, 32'd0, 1'b0);
            if (irq === 1'b1) first = i;
        end
        check("reload_first_irq", first, 32'd6);
        for (int k = 1; k <= 15; k++) begin
            int m;
            m = k % 5;
            drive(1'b0, 2'd2, 32'd0, 1'b0);
            check($sformatf("reload_irq[%0d]", k), {31'd0, irq}, (m == 0) ? 32'd1 : 32'd0);
            check($sformatf("reload_cnt[%0d]", k), dev_rd,
                  (m == 1) ? 32'd2 : (m == 2) ? 32'd1 : 32'd0);
        end

        // Pause at 6, then re-enable reloads from PRESET
        do_reset();
        drive(1'b0, 2'd1, 32'd10, 1'b1);
        drive(1'b0, 2'd0, 32'd1, 1'b1);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            drive(1'b0, 2'd2, 32'd0, 1'b0);
            if (dev_rd === 32'd7) begin
                found = 1;
                dev_addr = 2'd0; dev_wd = 32'd0; we_timer = 1'b1;
            end
        end
        check("pause_wait_found", found, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd2, 32'd0, 1'b0);
            check($sformatf("pause_hold[%0d]", i), dev_rd, 32'd6);
        end
        drive(1'b0, 2'd0, 32'd1, 1'b1);
        drive(1'b0, 2'd2, 32'd0, 1'b0);
        check("resume_e0", dev_rd, 32'd6);
        drive(1'b0, 2'd2, 32'd0, 1'b0);
        check("resume_e1", dev_rd, 32'd6);
        drive(1'b0, 2'd2, 32'd0, 1'b0);
        check("resume_reload", dev_rd, 32'd10);

        // IM=0 one-shot, then unmask with a CTRL write that clears pending
        do_reset();
        drive(1'b0, 2'd1, 32'd1, 1'b1);
        drive(1'b0, 2'd0, 32'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'd0, 32'd0, 1'b0);
            check($sformatf("masked_irq[%0d]", i), {31'd0, irq}, 32'd0);
        end
        check("masked_ctrl_done", dev_rd, 32'd0);
        drive(1'b0, 2'd0, 32'h8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 32'd0, 1'b0);
            check($sformatf("unmask_irq[%0d]", i), {31'd0, irq}, 32'd0);
        end
`else
        // Prescale 4, PRESET=2: each COUNT value lasts 4 clocks
        do_reset();
        drive(1'b0, 2'd1, 32'd2, 1'b1);
        drive(1'b0, 2'd0, 32'd1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 2'd2, 32'd0, 1'b0);
            check($sformatf("prescale_cnt[%0d]", k), dev_rd,
                  (k < 2) ? 32'd0 : (k < 6) ? 32'd2 : 32'd1);
        end
`endif

        // Reset mid-count aborts the run with no interrupt
        do_reset();
        drive(1'b0, 2'd1, 32'd5, 1'b1);
        drive(1'b0, 2'd0, 32'h9, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd2, 32'd0, 1'b0);
        drive(1'b1, 2'd2, 32'd0, 1'b0);
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 2'(a), 32'd0, 1'b0);
            check($sformatf("midreset_rd[%0d]", a), dev_rd, 32'd0);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 2'd2, 32'd0, 1'b0);
            check($sformatf("midreset_irq[%0d]", i), {31'd0, irq}, 32'd0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1)       drive(1'b1, 2'($urandom_range(0, 3)), 32'd0, 1'b0);
            else if (r < 13) drive(1'b0, 2'd0, $urandom, 1'b1);
            else if (r < 21) drive(1'b0, 2'd1, $urandom_range(0, 6), 1'b1);
            else if (r < 26) drive(1'b0, 2'($urandom_range(2, 3)), $urandom, 1'b1);
            else             drive(1'b0, 2'($urandom_range(0, 3)), 32'd0, 1'b0);
            check($sformatf("rand[%0d].rd", i), dev_rd, model_read(dev_addr));
            check($sformatf("rand[%0d].irq", i), {31'd0, irq}, {31'd0, m_irq});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
